// File: rtl/slave_rx_fifo.sv
// slave_rx_fifo
// Receives bytes from an upstream sender over a four-phase req/ack handshake
// and buffers them in a small FIFO for a downstream consumer. After NUM_BYTES
// complete handshakes the receiver parks in S_DONE. It stays there until reset,
// and the FIFO keeps draining while it waits.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req, data  : four-phase request and byte from the sender
//   ack        : registered four-phase acknowledge
//   out_valid  : FIFO non-empty
//   out_ready  : consumer takes the head byte on this edge
//   out_data   : head byte, 8'd0 when empty (combinational)
//   level      : FIFO occupancy
//   rx_count   : completed handshakes since reset (wraps at 256)
//   done       : registered, high in S_DONE
module slave_rx_fifo #(
  parameter int NUM_BYTES = 4,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req,
  input  logic [7:0]                 data,
  output logic                       ack,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [7:0]                 rx_count,
  output logic                       done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [7:0] NUM_BYTES_8 = 8'(NUM_BYTES);
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_WAIT_REQ_LOW = 2'd1,
    S_DONE         = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             ack_q, ack_d;
  logic             done_q, done_d;
  logic [7:0]       rx_count_q, rx_count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [7:0]       mem_q [DEPTH];

  logic push;
  logic pop;
  logic fifo_full;
  logic fifo_empty;

  assign fifo_full  = (level_q == FULL_LEVEL);
  assign fifo_empty = (level_q == '0);
  // The push decision looks only at the pre-edge level, so a same-edge pop
  // never makes room for a push.
  assign pop        = !fifo_empty && out_ready;

  always_comb begin
    state_d    = state_q;
    ack_d      = ack_q;
    done_d     = done_q;
    rx_count_d = rx_count_q;
    push       = 1'b0;
    case (state_q)
      S_IDLE: begin
        ack_d  = 1'b0;
        done_d = 1'b0;
        if (req && !fifo_full) begin
          push    = 1'b1;
          ack_d   = 1'b1;
          state_d = S_WAIT_REQ_LOW;
        end
      end
      S_WAIT_REQ_LOW: begin
        ack_d = 1'b1;
        if (!req) begin
          ack_d      = 1'b0;
          rx_count_d = rx_count_q + 8'd1;
          // Compare against the incremented count, all 8 bits.
          if (rx_count_d == NUM_BYTES_8) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DONE: begin
        ack_d  = 1'b0;
        done_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        ack_d   = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH by overflow.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
      rx_count_q <= 8'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      rx_count_q <= rx_count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  // Storage needs no reset; entries become visible only through level_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

  assign ack       = ack_q;
  assign done      = done_q;
  assign rx_count  = rx_count_q;
  assign level     = level_q;
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? 8'd0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_slave_rx_fifo.sv
// Bench for slave_rx_fifo. Two instances share clk, rst_n and all inputs:
// dut_a uses the default NUM_BYTES=4, DEPTH=4. dut_b uses NUM_BYTES=8, DEPTH=4,
// so it can still accept a fifth byte. A queue-based reference model tracks both.
module tb_slave_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [7:0] data = 8'd0;
  logic       out_ready = 1'b0;

  logic       a_ack, a_out_valid, a_done, b_ack, b_out_valid, b_done;
  logic [7:0] a_out_data, a_rx, b_out_data, b_rx;
  logic [2:0] a_level, b_level;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state, index 0 = dut_a, 1 = dut_b
  int         m_phase [2];   // 0 idle, 1 waiting for req low, 2 done
  logic [7:0] m_cnt   [2];
  logic [7:0] mq      [2][$];
  logic [7:0] popped_a [$];
  logic [7:0] popped_b [$];

  localparam int NB_A = 4;
  localparam int NB_B = 8;
  localparam int DEP  = 4;

  slave_rx_fifo #(.NUM_BYTES(NB_A), .DEPTH(DEP)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .ack(a_ack),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .level(a_level), .rx_count(a_rx), .done(a_done)
  );

  slave_rx_fifo #(.NUM_BYTES(NB_B), .DEPTH(DEP)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .ack(b_ack),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .level(b_level), .rx_count(b_rx), .done(b_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0;
      m_cnt[k]   = 8'd0;
      mq[k].delete();
    end
  endtask

  // One rising edge of the model, using the inputs present before the edge.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit do_pop;
      bit do_push;
      int nb;
      nb      = (k == 0) ? NB_A : NB_B;
      do_pop  = (mq[k].size() > 0) && out_ready;
      do_push = 1'b0;
      if (m_phase[k] == 0) begin
        if (req && mq[k].size() < DEP) begin
          do_push    = 1'b1;
          m_phase[k] = 1;
        end
      end else if (m_phase[k] == 1) begin
        if (!req) begin
          m_cnt[k]   = m_cnt[k] + 8'd1;
          m_phase[k] = (m_cnt[k] == 8'(nb)) ? 2 : 0;
        end
      end
      if (do_pop) void'(mq[k].pop_front());
      if (do_push) mq[k].push_back(data);
    end
  endtask

  task automatic compare_all(input string where);
    for (int k = 0; k < 2; k++) begin
      string p;
      logic [7:0] exp_head;
      p = $sformatf("%s.%s", where, (k == 0) ? "a" : "b");
      exp_head = (mq[k].size() > 0) ? mq[k][0] : 8'd0;
      chk({p, ".ack"},       (k == 0) ? a_ack : b_ack, 32'(m_phase[k] == 1));
      chk({p, ".done"},      (k == 0) ? a_done : b_done, 32'(m_phase[k] == 2));
      chk({p, ".level"},     (k == 0) ? a_level : b_level, mq[k].size());
      chk({p, ".out_valid"}, (k == 0) ? a_out_valid : b_out_valid, 32'(mq[k].size() > 0));
      chk({p, ".out_data"},  (k == 0) ? a_out_data : b_out_data, exp_head);
      chk({p, ".rx_count"},  (k == 0) ? a_rx : b_rx, m_cnt[k]);
    end
  endtask

  task automatic tick();
    if (a_out_valid && out_ready) popped_a.push_back(a_out_data);
    if (b_out_valid && out_ready) popped_b.push_back(b_out_data);
    @(posedge clk);
    model_step();
    #1;
    compare_all("cyc");
  endtask

  // Assert reset between edges and check the outputs clear with no clock edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("rst");
    popped_a.delete();
    popped_b.delete();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] byte_v, input bit sel_b);
    int n;
    req  = 1'b1;
    data = byte_v;
    n    = 0;
    do begin
      tick();
      n++;
    end while (((sel_b ? b_ack : a_ack) == 1'b0) && n < 20);
    chk("send.ack_rise", sel_b ? b_ack : a_ack, 1);
    req = 1'b0;
    tick();
    chk("send.ack_fall", sel_b ? b_ack : a_ack, 0);
  endtask

  initial begin
    logic [7:0] exp_bytes [5];
    model_reset();
    #12;
    compare_all("por");
    rst_n = 1'b1;

    // Four bytes streamed straight through with the consumer always ready.
    out_ready = 1'b1;
    exp_bytes = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00};
    for (int i = 0; i < 4; i++) send(exp_bytes[i], 1'b0);
    tick();
    chk("stream.popped_n", popped_a.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("stream.byte%0d", i), (i < popped_a.size()) ? popped_a[i] : 8'hXX, exp_bytes[i]);
    chk("stream.rx_count", a_rx, 4);
    chk("stream.done", a_done, 1);
    chk("stream.ack", a_ack, 0);

    // A request after done is ignored by dut_a.
    req = 1'b1; data = 8'hFF;
    repeat (3) begin
      tick();
      chk("done.ack", a_ack, 0);
      chk("done.level", a_level, 0);
      chk("done.rx_count", a_rx, 4);
    end
    req = 1'b0;
    tick();

    // Backpressure on dut_b: four bytes fill it and the fifth waits.
    async_reset();
    out_ready = 1'b0;
    exp_bytes = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    for (int i = 0; i < 4; i++) send(exp_bytes[i], 1'b1);
    chk("bp.level_full", b_level, 4);
    req = 1'b1; data = exp_bytes[4];
    repeat (3) begin
      tick();
      chk("bp.ack_low", b_ack, 0);
      chk("bp.level", b_level, 4);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp.level_after_pop", b_level, 3);
    tick();
    chk("bp.fifth_ack", b_ack, 1);
    chk("bp.fifth_level", b_level, 4);
    req = 1'b0;
    tick();
    out_ready = 1'b1;
    repeat (5) tick();
    out_ready = 1'b0;
    chk("bp.popped_n", popped_b.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("bp.byte%0d", i), (i < popped_b.size()) ? popped_b[i] : 8'hXX, exp_bytes[i]);

    // A long req gives exactly one push.
    async_reset();
    out_ready = 1'b0;
    req = 1'b1; data = 8'h55;
    tick();
    chk("hold.ack_rise", a_ack, 1);
    repeat (10) begin
      tick();
      chk("hold.ack", a_ack, 1);
      chk("hold.level", a_level, 1);
    end
    req = 1'b0;
    tick();
    chk("hold.ack_fall", a_ack, 0);
    chk("hold.rx_count", a_rx, 1);

    // Push and pop on the same edge at level 2.
    async_reset();
    out_ready = 1'b0;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    chk("pp.level_before", a_level, 2);
    req = 1'b1; data = 8'h33; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pp.level", a_level, 2);
    chk("pp.head", a_out_data, 8'h22);
    req = 1'b0;
    tick();

    // Reset in the middle of a handshake, with req still high on release.
    async_reset();
    out_ready = 1'b0;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    req = 1'b1; data = 8'h03;
    tick();
    chk("mid.ack_before", a_ack, 1);
    chk("mid.level_before", a_level, 3);
    data = 8'h77;
    async_reset();
    chk("mid.ack", a_ack, 0);
    chk("mid.level", a_level, 0);
    chk("mid.out_valid", a_out_valid, 0);
    tick();
    chk("mid.new_ack", a_ack, 1);
    chk("mid.new_head", a_out_data, 8'h77);
    req = 1'b0;
    tick();
    chk("mid.rx_count", a_rx, 1);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 60) == 0) async_reset();
      req       = ($urandom_range(0, 2) != 0);
      data      = 8'($urandom);
      out_ready = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
